traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning), one per line:
- BASE_SEL, 2'b00, interval code for the base interval
- EXT_SEL, 2'b01, interval code for the extended interval
- YEL_SEL, 2'b10, interval code for the yellow interval
REQ-002 The module SHALL have these ports (name  direction  width  meaning), one per line:
- clk  in  1  single system clock, all logic on the rising edge
- global_reset_n  in  1  reset, synchronous, active-low
- one_hz_enable  in  1  one-cycle tick per second from the divider
- sensor_sync  in  1  side-street car present (already synchronised)
- walk_request_sync  in  1  pedestrian button (already synchronised)
- reprogram  in  1  interval store is being rewritten
- time_value  in  4  seconds for the interval requested last cycle
- interval_request  out  2  interval code driven to the interval store
- main_lights  out  3  {red,yellow,green}, main street
- side_lights  out  3  {red,yellow,green}, side street
- walk_lamp  out  1  pedestrian walk indication

Function
REQ-003 The phase FSM SHALL have these states: MG_BASE, MG_EXT, M_YEL, WALK, SG_BASE, SG_EXT, S_YEL.
REQ-004 Lights per state SHALL be:
- MG_*: main 001, side 100
- M_YEL: main 010, side 100
- WALK: main 100, side 100, walk_lamp 1
- SG_*: main 100, side 001
- S_YEL: main 100, side 010
- walk_lamp SHALL be 0 in every other state.
REQ-005 interval_request SHALL be a registered output: BASE_SEL in MG_BASE and SG_BASE; EXT_SEL in MG_EXT, SG_EXT and WALK; YEL_SEL in M_YEL and S_YEL.
REQ-006 On each state entry, the FSM SHALL wait exactly 2 clk cycles and then load the countdown timer from time_value; this covers the interval store's one-cycle registered latency.
REQ-007 A time_value of 0 SHALL load as 1.
REQ-008 The timer SHALL decrement on one_hz_enable while loaded; it SHALL assert expire for one cycle on the one_hz_enable tick when the count is 1. A phase of N therefore lasts N ticks after the load.
REQ-009 one_hz_enable ticks during the 2-cycle load wait SHALL be ignored.
REQ-010 State transitions SHALL occur only on expire:
- MG_BASE -> MG_EXT if sensor_sync=1 at expiry, else M_YEL
- MG_EXT -> M_YEL
- M_YEL -> WALK if walk_pending=1, else SG_BASE
- WALK -> SG_BASE
- SG_BASE -> SG_EXT if sensor_sync=1 at expiry, else S_YEL
- SG_EXT -> S_YEL
- S_YEL -> MG_BASE
REQ-011 walk_pending SHALL set on any cycle with walk_request_sync=1 and clear on entry to WALK; if a set and a clear occur in the same cycle, set SHALL win only when the FSM is not in WALK.
REQ-012 While reprogram=1, the FSM SHALL hold in MG_BASE with the timer idle; on reprogram falling, the FSM SHALL restart MG_BASE with a fresh 2-cycle load wait. walk_pending SHALL be preserved across reprogram.
REQ-013 If expire and reprogram coincide, reprogram SHALL take priority.
REQ-014 Exactly one lamp per street SHALL be lit every cycle, and main and side SHALL never be non-red simultaneously.

Reset
REQ-015 When global_reset_n=0 at a clk edge, the module SHALL set:
- state MG_BASE
- load-wait counter 0
- timer count 0, not loaded
- walk_pending 0
- interval_request BASE_SEL
- main_lights 001, side_lights 100, walk_lamp 0
REQ-016 A reset asserted mid-phase SHALL abort the phase; after release, the first timer load SHALL occur 2 cycles later.

Structure
REQ-017 The interval codes and the state encoding SHALL live in a shared package/include file that is also used by the interval store.
REQ-018 The countdown timer SHALL be one sub-module, interval_timer (ports: load, value[3:0], tick, expire); the FSM and light decode SHALL reside in traffic_light_fsm.

Verification
REQ-019 The bench SHALL cover these directed scenarios (intervals 6/3/2, sensor_sync=0, no walk):
- Idle cycle -> MG 6 ticks, M_YEL 2, SG 6, S_YEL 2, repeat; interval_request sequence 00,10,00,10.
- sensor_sync=1 throughout -> MG 6+3 ticks, SG 6+3 ticks; interval_request visits 01.
- walk_request_sync pulsed 1 cycle during MG_BASE -> after M_YEL, WALK for 3 ticks with walk_lamp=1 and all red; the next cycle has no WALK.
- Tick coincident with the 2nd load-wait cycle -> ignored; phase length unchanged.
- time_value forced to 0 -> phase lasts 1 tick; reprogram pulsed mid-SG_BASE -> returns to MG_BASE, main green 2 cycles later loaded.
- global_reset_n=0 mid-S_YEL -> next edge all outputs at reset values; every cycle checks the REQ-014 assertion.

Source files
------------

// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the traffic light controller and its interval store:
// interval codes, phase encoding and the lamp decode for each phase.
package traffic_light_fsm_pkg;

  // Interval codes understood by the interval store
  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  // Phase encoding
  localparam logic [2:0] ST_MG_BASE = 3'd0;
  localparam logic [2:0] ST_MG_EXT  = 3'd1;
  localparam logic [2:0] ST_M_YEL   = 3'd2;
  localparam logic [2:0] ST_WALK    = 3'd3;
  localparam logic [2:0] ST_SG_BASE = 3'd4;
  localparam logic [2:0] ST_SG_EXT  = 3'd5;
  localparam logic [2:0] ST_S_YEL   = 3'd6;

  // Lamp patterns, {red,yellow,green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
  } lamps_t;

  // Lamp pattern for a phase; unknown encodings fall back to all-red.
  function automatic lamps_t decode_lamps(input logic [2:0] st);
    lamps_t l;
    l.main = LAMP_RED;
    l.side = LAMP_RED;
    l.walk = 1'b0;
    case (st)
      ST_MG_BASE, ST_MG_EXT: l.main = LAMP_GRN;
      ST_M_YEL:              l.main = LAMP_YEL;
      ST_WALK:               l.walk = 1'b1;
      ST_SG_BASE, ST_SG_EXT: l.side = LAMP_GRN;
      ST_S_YEL:              l.side = LAMP_YEL;
      default:               l.walk = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_fsm_interval_timer.sv
// Countdown timer for one phase. Loaded once per phase, counts down on the
// one-second tick and flags expiry on the tick that consumes the last second.
module interval_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       tick,
  output logic       expire
);

  logic [3:0] count_q, count_d;
  logic       loaded_q, loaded_d;

  assign expire = loaded_q && tick && (count_q == 4'd1);

  // Next count: clear beats load, load beats counting; a zero interval runs one tick
  always_comb begin
    count_d  = count_q;
    loaded_d = loaded_q;
    if (clear) begin
      count_d  = 4'd0;
      loaded_d = 1'b0;
    end else if (load) begin
      count_d  = (value == 4'd0) ? 4'd1 : value;
      loaded_d = 1'b1;
    end else if (loaded_q && tick) begin
      if (count_q == 4'd1) begin
        count_d  = 4'd0;
        loaded_d = 1'b0;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  // Timer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 4'd0;
      loaded_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic light phase controller: sequences main/side/walk phases, requests
// each phase's interval from an external store and times it with interval_timer.
module traffic_light_fsm
  import traffic_light_fsm_pkg::*;
#(
  parameter logic [1:0] BASE_SEL = SEL_BASE,
  parameter logic [1:0] EXT_SEL  = SEL_EXT,
  parameter logic [1:0] YEL_SEL  = SEL_YEL
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       one_hz_enable,
  input  logic       sensor_sync,
  input  logic       walk_request_sync,
  input  logic       reprogram,
  input  logic [3:0] time_value,
  output logic [1:0] interval_request,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp
);

  // Load wait: 0 and 1 are waiting (store still answering), 2 means loaded
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [2:0] state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic       walk_pending_q, walk_pending_d;
  logic [1:0] interval_request_q, interval_request_d;
  logic       expire;
  logic       timer_load;
  logic       entering_walk;
  lamps_t     lamps;

  // The store answers one cycle after the request, so load on the second wait cycle
  assign timer_load = (wait_q == 2'd1) && !reprogram;

  interval_timer u_timer (
    .clk    (clk),
    .rst_n  (global_reset_n),
    .clear  (reprogram),
    .load   (timer_load),
    .value  (time_value),
    .tick   (one_hz_enable),
    .expire (expire)
  );

  // Phase sequencing; reprogram overrides expiry and restarts the main green
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (reprogram) begin
      state_d = ST_MG_BASE;
      wait_d  = 2'd0;
    end else if (expire) begin
      wait_d = 2'd0;
      case (state_q)
        ST_MG_BASE: state_d = sensor_sync ? ST_MG_EXT : ST_M_YEL;
        ST_MG_EXT:  state_d = ST_M_YEL;
        ST_M_YEL:   state_d = walk_pending_q ? ST_WALK : ST_SG_BASE;
        ST_WALK:    state_d = ST_SG_BASE;
        ST_SG_BASE: state_d = sensor_sync ? ST_SG_EXT : ST_S_YEL;
        ST_SG_EXT:  state_d = ST_S_YEL;
        ST_S_YEL:   state_d = ST_MG_BASE;
        default:    state_d = ST_MG_BASE;
      endcase
    end else if (wait_q != WAIT_DONE) begin
      wait_d = wait_q + 2'd1;
    end
  end

  // A request arriving on the very cycle WALK is entered is served by that walk
  assign entering_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

  // Pending pedestrian request latch
  always_comb begin
    walk_pending_d = walk_pending_q;
    if (entering_walk) begin
      walk_pending_d = 1'b0;
    end else if (walk_request_sync) begin
      walk_pending_d = 1'b1;
    end
  end

  // Interval code for the phase being entered, registered alongside the state
  always_comb begin
    case (state_d)
      ST_MG_EXT, ST_SG_EXT, ST_WALK: interval_request_d = EXT_SEL;
      ST_M_YEL, ST_S_YEL:            interval_request_d = YEL_SEL;
      default:                       interval_request_d = BASE_SEL;
    endcase
  end

  // Controller registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!global_reset_n) begin
      state_q            <= ST_MG_BASE;
      wait_q             <= 2'd0;
      walk_pending_q     <= 1'b0;
      interval_request_q <= BASE_SEL;
    end else begin
      state_q            <= state_d;
      wait_q             <= wait_d;
      walk_pending_q     <= walk_pending_d;
      interval_request_q <= interval_request_d;
    end
  end

  assign lamps            = decode_lamps(state_q);
  assign main_lights      = lamps.main;
  assign side_lights      = lamps.side;
  assign walk_lamp        = lamps.walk;
  assign interval_request = interval_request_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with a tick-level behavioural model,
// an interval store model (6/3/2 seconds) and per-cycle output comparison.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       global_reset_n = 1'b0;
  logic       one_hz_enable = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       walk_request_sync = 1'b0;
  logic       reprogram = 1'b0;
  logic [3:0] time_value;
  logic [1:0] interval_request;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  int checks = 0;
  int errors = 0;
  bit force_zero = 1'b0;
  bit cmp_en = 1'b0;

  // Model phases (bench-local numbering)
  localparam int P_MGB = 11, P_MGE = 12, P_MY = 13, P_WK = 20, P_SGB = 31, P_SGE = 32, P_SY = 33;

  int m_phase = P_MGB;
  int m_age   = 0;   // cycles since phase entry, saturating at 2
  int m_left  = 0;   // ticks left in the phase, 0 = not yet loaded
  bit m_pend  = 1'b0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk               (clk),
    .global_reset_n    (global_reset_n),
    .one_hz_enable     (one_hz_enable),
    .sensor_sync       (sensor_sync),
    .walk_request_sync (walk_request_sync),
    .reprogram         (reprogram),
    .time_value        (time_value),
    .interval_request  (interval_request),
    .main_lights       (main_lights),
    .side_lights       (side_lights),
    .walk_lamp         (walk_lamp)
  );

  function automatic logic [3:0] secs_for(input logic [1:0] code);
    case (code)
      2'b00:   return 4'd6;
      2'b01:   return 4'd3;
      2'b10:   return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // Interval store: one-cycle registered lookup
  always @(posedge clk) time_value <= force_zero ? 4'd0 : secs_for(interval_request);

  function automatic int exp_main(input int p);
    if (p == P_MGB || p == P_MGE) return 1;
    if (p == P_MY) return 2;
    return 4;
  endfunction

  function automatic int exp_side(input int p);
    if (p == P_SGB || p == P_SGE) return 1;
    if (p == P_SY) return 2;
    return 4;
  endfunction

  function automatic int exp_code(input int p);
    if (p == P_MGB || p == P_SGB) return 0;
    if (p == P_MY || p == P_SY) return 2;
    return 1;
  endfunction

  function automatic int next_phase(input int p, input bit sens, input bit pend);
    case (p)
      P_MGB:   return sens ? P_MGE : P_MY;
      P_MGE:   return P_MY;
      P_MY:    return pend ? P_WK : P_SGB;
      P_WK:    return P_SGB;
      P_SGB:   return sens ? P_SGE : P_SY;
      P_SGE:   return P_SY;
      default: return P_MGB;
    endcase
  endfunction

  function automatic int phase_ticks(input int p);
    int d;
    d = force_zero ? 0 : int'(secs_for(2'(exp_code(p))));
    return (d == 0) ? 1 : d;
  endfunction

  // Advance the model by one clock with the inputs the DUT sampled
  task automatic model_step(input bit rst_n, input bit tick, input bit sens,
                            input bit walk, input bit rp);
    bit exp;
    int nxt;
    if (!rst_n) begin
      m_phase = P_MGB; m_age = 0; m_left = 0; m_pend = 1'b0;
      return;
    end
    exp = (m_left == 1) && tick;
    if (rp) begin
      m_phase = P_MGB; m_age = 0; m_left = 0; m_pend = m_pend | walk;
      return;
    end
    if (exp) begin
      nxt = next_phase(m_phase, sens, m_pend);
      m_pend = (nxt == P_WK) ? 1'b0 : (m_pend | walk);
      m_phase = nxt; m_age = 0; m_left = 0;
      return;
    end
    m_pend = m_pend | walk;
    if (tick && m_left > 0) m_left = m_left - 1;
    if (m_age == 1) m_left = phase_ticks(m_phase);
    if (m_age < 2) m_age = m_age + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model plus lamp safety
  always @(negedge clk) begin
    if (cmp_en) begin
      check("main_lights", int'(main_lights), exp_main(m_phase));
      check("side_lights", int'(side_lights), exp_side(m_phase));
      check("walk_lamp", int'(walk_lamp), (m_phase == P_WK) ? 1 : 0);
      check("interval_request", int'(interval_request), exp_code(m_phase));
      check("main_onehot", int'($onehot(main_lights)), 1);
      check("side_onehot", int'($onehot(side_lights)), 1);
      check("no_conflict", int'(main_lights != 3'b100 && side_lights != 3'b100), 0);
    end
  end

  task automatic step(input bit tick, input bit walk);
    @(negedge clk);
    one_hz_enable     = tick;
    walk_request_sync = walk;
    @(posedge clk);
    model_step(global_reset_n, tick, sensor_sync, walk, reprogram);
    #1;
  endtask

  function automatic logic [8:0] sig();
    return {main_lights, side_lights, walk_lamp, interval_request};
  endfunction

  // Run the current phase from its entry: two wait cycles, then ticks separated
  // by idle cycles until the outputs change; compare the tick count.
  task automatic measure(input string name, input int exp_ticks,
                         input bit tick_in_wait, input bit walk_in_wait);
    logic [8:0] sig0;
    int n;
    bit done;
    sig0 = sig();
    step(1'b0, walk_in_wait);
    step(tick_in_wait, 1'b0);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, 1'b0);
      n++;
      if (sig() != sig0) done = 1'b1;
      else step(1'b0, 1'b0);
    end
    check({name, "_ticks"}, n, exp_ticks);
  endtask

  task automatic expect_out(input string name, input logic [1:0] ireq,
                            input logic [2:0] m, input logic [2:0] s, input logic w);
    check({name, "_ireq"}, int'(interval_request), int'(ireq));
    check({name, "_main"}, int'(main_lights), int'(m));
    check({name, "_side"}, int'(side_lights), int'(s));
    check({name, "_walk"}, int'(walk_lamp), int'(w));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    global_reset_n = 1'b0;
    step(1'b0, 1'b0);
    cmp_en = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_out("reset", 2'b00, 3'b001, 3'b100, 1'b0);
    global_reset_n = 1'b1;
    $display("txn: reset released");

    // Idle cycle
    measure("idle_mg", 6, 1'b0, 1'b0);   expect_out("idle_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    measure("idle_myel", 2, 1'b0, 1'b0); expect_out("idle_to_sg", 2'b00, 3'b100, 3'b001, 1'b0);
    measure("idle_sg", 6, 1'b0, 1'b0);   expect_out("idle_to_syel", 2'b10, 3'b100, 3'b010, 1'b0);
    measure("idle_syel", 2, 1'b0, 1'b0); expect_out("idle_to_mg", 2'b00, 3'b001, 3'b100, 1'b0);
    $display("txn: idle cycle done");

    // Sensor held high
    sensor_sync = 1'b1;
    measure("sens_mg", 6, 1'b0, 1'b0);    expect_out("sens_to_mgext", 2'b01, 3'b001, 3'b100, 1'b0);
    measure("sens_mgext", 3, 1'b0, 1'b0); expect_out("sens_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    measure("sens_myel", 2, 1'b0, 1'b0);  expect_out("sens_to_sg", 2'b00, 3'b100, 3'b001, 1'b0);
    measure("sens_sg", 6, 1'b0, 1'b0);    expect_out("sens_to_sgext", 2'b01, 3'b100, 3'b001, 1'b0);
    measure("sens_sgext", 3, 1'b0, 1'b0); expect_out("sens_to_syel", 2'b10, 3'b100, 3'b010, 1'b0);
    measure("sens_syel", 2, 1'b0, 1'b0);  expect_out("sens_to_mg", 2'b00, 3'b001, 3'b100, 1'b0);
    sensor_sync = 1'b0;
    $display("txn: sensor cycle done");

    // Pedestrian request pulsed during MG_BASE
    measure("walk_mg", 6, 1'b0, 1'b1);    expect_out("walk_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    measure("walk_myel", 2, 1'b0, 1'b0);  expect_out("walk_to_walk", 2'b01, 3'b100, 3'b100, 1'b1);
    measure("walk_walk", 3, 1'b0, 1'b0);  expect_out("walk_to_sg", 2'b00, 3'b100, 3'b001, 1'b0);
    measure("walk_sg", 6, 1'b0, 1'b0);    expect_out("walk_to_syel", 2'b10, 3'b100, 3'b010, 1'b0);
    measure("walk_syel", 2, 1'b0, 1'b0);  expect_out("walk_to_mg", 2'b00, 3'b001, 3'b100, 1'b0);
    measure("walk_mg2", 6, 1'b0, 1'b0);   expect_out("walk_to_myel2", 2'b10, 3'b010, 3'b100, 1'b0);
    measure("walk_myel2", 2, 1'b0, 1'b0); expect_out("nowalk_to_sg", 2'b00, 3'b100, 3'b001, 1'b0);
    measure("walk_sg2", 6, 1'b0, 1'b0);
    measure("walk_syel2", 2, 1'b0, 1'b0); expect_out("walk_back_mg", 2'b00, 3'b001, 3'b100, 1'b0);
    $display("txn: walk cycle done");

    // Tick on the second load-wait cycle is ignored
    measure("waittick_mg", 6, 1'b1, 1'b0); expect_out("waittick_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    measure("waittick_myel", 2, 1'b0, 1'b0);
    measure("waittick_sg", 6, 1'b0, 1'b0);
    measure("waittick_syel", 2, 1'b0, 1'b0);
    $display("txn: wait-cycle tick done");

    // Zero interval loads as one tick
    force_zero = 1'b1;
    measure("zero_mg", 1, 1'b0, 1'b0);  expect_out("zero_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    force_zero = 1'b0;
    measure("zero_myel", 2, 1'b0, 1'b0); expect_out("zero_to_sg", 2'b00, 3'b100, 3'b001, 1'b0);
    $display("txn: zero interval done");

    // Reprogram mid SG_BASE
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reprogram = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    expect_out("reprog", 2'b00, 3'b001, 3'b100, 1'b0);
    reprogram = 1'b0;
    measure("reprog_mg", 6, 1'b0, 1'b0); expect_out("reprog_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    $display("txn: reprogram done");

    // Reset in the middle of S_YEL
    measure("rst_myel", 2, 1'b0, 1'b0);
    measure("rst_sg", 6, 1'b0, 1'b0);   expect_out("rst_in_syel", 2'b10, 3'b100, 3'b010, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    global_reset_n = 1'b0;
    step(1'b0, 1'b0);
    expect_out("rst_mid", 2'b00, 3'b001, 3'b100, 1'b0);
    global_reset_n = 1'b1;
    measure("rst_mg", 6, 1'b0, 1'b0);   expect_out("rst_to_myel", 2'b10, 3'b010, 3'b100, 1'b0);
    $display("txn: mid-phase reset done");

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
